// File: rtl/im_downscale.sv
// im_downscale
// Reads a pIN_IM_WIDTH x pIN_IM_HEIGHT frame, reduces it by pSCALE per axis
// and writes OUT_W x OUT_H pixels. Each output pixel is either the per-channel
// mean of its pSCALE x pSCALE block (imode=0) or the block's top-left pixel
// (imode=1).
// Build option IM_DOWNSCALE_ROUND_EN: round the mean to nearest with
// saturation; when undefined the mean is a plain truncating shift.
//
// Handshake: there is no valid/ready pairing. istart_work is sampled only in
// IDLE. idata_rd is consumed exactly one cycle after each omem_rd_en cycle.
// omem_wr_en is a one-cycle strobe per output pixel.
module im_downscale #(
   parameter int pIN_IM_WIDTH  = 640,
   parameter int pIN_IM_HEIGHT = 480,
   parameter int pSCALE        = 4,
   parameter int pCHANNELS     = 3,
   parameter int pCH_W         = 8,
   localparam int OUT_W  = pIN_IM_WIDTH / pSCALE,
   localparam int OUT_H  = pIN_IM_HEIGHT / pSCALE,
   localparam int IN_AW  = $clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT),
   localparam int OUT_AW = $clog2(OUT_W * OUT_H),
   localparam int LS     = $clog2(pSCALE),
   localparam int PW     = pCHANNELS * pCH_W
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic [PW-1:0]     idata_rd,
   output logic [IN_AW-1:0]  oaddr_rd,
   output logic              omem_rd_en,
   output logic [PW-1:0]     odata_wr,
   output logic [OUT_AW-1:0] oaddr_wr,
   output logic              omem_wr_en,
   input  logic [IN_AW-1:0]  irbase,
   input  logic [OUT_AW-1:0] iwbase,
   input  logic              imode,
   input  logic              istart_work,
   output logic              omodule_work_f,
   output logic              omodule_done_f
);

   localparam int ACC_W = pCH_W + 2 * LS;
   localparam int KW    = (LS > 0) ? LS : 1;
   localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [IN_AW-1:0] COL_STEP  = IN_AW'(pSCALE);
   localparam logic [IN_AW-1:0] LINE_STEP = IN_AW'(pIN_IM_WIDTH);
   localparam logic [IN_AW-1:0] ROW_STEP  = IN_AW'(pSCALE * pIN_IM_WIDTH);

   typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_LAST, ST_WRITE, ST_DONE} state_e;

   state_e            state_q;
   logic              mode_q;
   logic [KW-1:0]     kx_q, ky_q;
   logic [XW-1:0]     ox_q;
   logic [YW-1:0]     oy_q;
   // row_q: first pixel of the current block row, blk_q: block top-left,
   // line_q: first pixel of the block line being read
   logic [IN_AW-1:0]  row_q, blk_q, line_q, rd_addr_q;
   logic [OUT_AW-1:0] wr_addr_q;
   logic              rd_en_q, wr_en_q, work_q, done_q;
   logic              smp_v_q, smp_first_q;
   logic [PW-1:0]     wr_data_q;
   logic [pCHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [PW-1:0]     avg_w;
   logic              kx_last, ky_last, ox_last, oy_last;

   assign kx_last = (kx_q == KW'(pSCALE - 1));
   assign ky_last = (ky_q == KW'(pSCALE - 1));
   assign ox_last = (ox_q == XW'(OUT_W - 1));
   assign oy_last = (oy_q == YW'(OUT_H - 1));

`ifdef IM_DOWNSCALE_ROUND_EN
   // Half of 2^(2*LS); evaluates to zero when pSCALE=1 so no bias is added
   localparam logic [ACC_W:0] RND_ADD = (ACC_W + 1)'((1 << (2 * LS)) >> 1);
   localparam logic [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << pCH_W) - 1);
   logic [ACC_W:0] rnd_w, shf_w;
`endif

   // Accumulate each returning sample; the first sample of a block reloads
   always_comb begin
      acc_d = acc_q;
      avg_w = '0;
`ifdef IM_DOWNSCALE_ROUND_EN
      rnd_w = '0;
      shf_w = '0;
`endif
      for (int c = 0; c < pCHANNELS; c++) begin
         if (smp_v_q) begin
            if (smp_first_q) acc_d[c] = ACC_W'(idata_rd[c*pCH_W +: pCH_W]);
            else             acc_d[c] = acc_q[c] + ACC_W'(idata_rd[c*pCH_W +: pCH_W]);
         end
`ifdef IM_DOWNSCALE_ROUND_EN
         rnd_w = {1'b0, acc_d[c]} + RND_ADD;
         shf_w = rnd_w >> (2 * LS);
         if (shf_w > SAT_MAX) avg_w[c*pCH_W +: pCH_W] = '1;
         else                 avg_w[c*pCH_W +: pCH_W] = shf_w[pCH_W-1:0];
`else
         avg_w[c*pCH_W +: pCH_W] = pCH_W'(acc_d[c] >> (2 * LS));
`endif
      end
   end

   // Accumulator register
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) acc_q <= '0;
      else         acc_q <= acc_d;
   end

   // Control FSM: counters, address pointers and registered outputs
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= 1'b0;
         kx_q        <= '0;
         ky_q        <= '0;
         ox_q        <= '0;
         oy_q        <= '0;
         row_q       <= '0;
         blk_q       <= '0;
         line_q      <= '0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         work_q      <= 1'b0;
         done_q      <= 1'b0;
         smp_v_q     <= 1'b0;
         smp_first_q <= 1'b0;
      end else begin
         smp_v_q     <= rd_en_q;
         smp_first_q <= rd_en_q && (kx_q == '0) && (ky_q == '0);
         case (state_q)
            ST_IDLE: begin
               if (istart_work) begin
                  mode_q    <= imode;
                  kx_q      <= '0;
                  ky_q      <= '0;
                  ox_q      <= '0;
                  oy_q      <= '0;
                  row_q     <= irbase;
                  blk_q     <= irbase;
                  line_q    <= irbase;
                  rd_addr_q <= irbase;
                  wr_addr_q <= iwbase;
                  rd_en_q   <= 1'b1;
                  work_q    <= 1'b1;
                  state_q   <= ST_READ;
               end
            end
            ST_READ: begin
               if (mode_q || (kx_last && ky_last)) begin
                  kx_q    <= '0;
                  ky_q    <= '0;
                  rd_en_q <= 1'b0;
                  state_q <= ST_LAST;
               end else if (!kx_last) begin
                  kx_q      <= kx_q + 1'b1;
                  rd_addr_q <= rd_addr_q + 1'b1;
               end else begin
                  kx_q      <= '0;
                  ky_q      <= ky_q + 1'b1;
                  line_q    <= line_q + LINE_STEP;
                  rd_addr_q <= line_q + LINE_STEP;
               end
            end
            ST_LAST: begin
               wr_data_q <= mode_q ? idata_rd : avg_w;
               wr_en_q   <= 1'b1;
               state_q   <= ST_WRITE;
            end
            ST_WRITE: begin
               wr_en_q   <= 1'b0;
               wr_data_q <= '0;
               wr_addr_q <= wr_addr_q + 1'b1;
               if (ox_last && oy_last) begin
                  work_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  if (ox_last) begin
                     ox_q      <= '0;
                     oy_q      <= oy_q + 1'b1;
                     row_q     <= row_q + ROW_STEP;
                     blk_q     <= row_q + ROW_STEP;
                     line_q    <= row_q + ROW_STEP;
                     rd_addr_q <= row_q + ROW_STEP;
                  end else begin
                     ox_q      <= ox_q + 1'b1;
                     blk_q     <= blk_q + COL_STEP;
                     line_q    <= blk_q + COL_STEP;
                     rd_addr_q <= blk_q + COL_STEP;
                  end
                  rd_en_q <= 1'b1;
                  state_q <= ST_READ;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign oaddr_rd       = rd_addr_q;
   assign omem_rd_en     = rd_en_q;
   assign odata_wr       = wr_data_q;
   assign oaddr_wr       = wr_addr_q;
   assign omem_wr_en     = wr_en_q;
   assign omodule_work_f = work_q;
   assign omodule_done_f = done_q;

endmodule

// File: tb/tb_im_downscale.sv
// tb_im_downscale: directed checks of im_downscale on three configurations:
//   A: 8x4, pSCALE=2 (average, rounding, decimate, control, reset)
//   C: 16x16, pSCALE=2 (base offsets and address wrap)
//   D: 4x2, pSCALE=1 (straight copy)
module tb_im_downscale;

`ifdef IM_DOWNSCALE_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A ----------------
   logic [23:0] a_data_rd, a_data_wr;
   logic [4:0]  a_addr_rd, a_rbase;
   logic [2:0]  a_addr_wr, a_wbase;
   logic        a_rd_en, a_wr_en, a_mode, a_start, a_work, a_done;
   logic [23:0] a_mem [32];

   im_downscale #(.pIN_IM_WIDTH(8), .pIN_IM_HEIGHT(4), .pSCALE(2),
                  .pCHANNELS(3), .pCH_W(8)) u_a (
      .iclk(clk), .irst_n(rst_n), .idata_rd(a_data_rd), .oaddr_rd(a_addr_rd),
      .omem_rd_en(a_rd_en), .odata_wr(a_data_wr), .oaddr_wr(a_addr_wr),
      .omem_wr_en(a_wr_en), .irbase(a_rbase), .iwbase(a_wbase), .imode(a_mode),
      .istart_work(a_start), .omodule_work_f(a_work), .omodule_done_f(a_done));

   // ---------------- DUT C ----------------
   logic [23:0] c_data_rd, c_data_wr;
   logic [7:0]  c_addr_rd, c_rbase;
   logic [5:0]  c_addr_wr, c_wbase;
   logic        c_rd_en, c_wr_en, c_mode, c_start, c_work, c_done;
   logic [23:0] c_mem [256];

   im_downscale #(.pIN_IM_WIDTH(16), .pIN_IM_HEIGHT(16), .pSCALE(2),
                  .pCHANNELS(3), .pCH_W(8)) u_c (
      .iclk(clk), .irst_n(rst_n), .idata_rd(c_data_rd), .oaddr_rd(c_addr_rd),
      .omem_rd_en(c_rd_en), .odata_wr(c_data_wr), .oaddr_wr(c_addr_wr),
      .omem_wr_en(c_wr_en), .irbase(c_rbase), .iwbase(c_wbase), .imode(c_mode),
      .istart_work(c_start), .omodule_work_f(c_work), .omodule_done_f(c_done));

   // ---------------- DUT D ----------------
   logic [23:0] d_data_rd, d_data_wr;
   logic [2:0]  d_addr_rd, d_rbase;
   logic [2:0]  d_addr_wr, d_wbase;
   logic        d_rd_en, d_wr_en, d_mode, d_start, d_work, d_done;
   logic [23:0] d_mem [8];

   im_downscale #(.pIN_IM_WIDTH(4), .pIN_IM_HEIGHT(2), .pSCALE(1),
                  .pCHANNELS(3), .pCH_W(8)) u_d (
      .iclk(clk), .irst_n(rst_n), .idata_rd(d_data_rd), .oaddr_rd(d_addr_rd),
      .omem_rd_en(d_rd_en), .odata_wr(d_data_wr), .oaddr_wr(d_addr_wr),
      .omem_wr_en(d_wr_en), .irbase(d_rbase), .iwbase(d_wbase), .imode(d_mode),
      .istart_work(d_start), .omodule_work_f(d_work), .omodule_done_f(d_done));

   // Frame memories: data one cycle after the read strobe
   always @(posedge clk) begin
      if (a_rd_en) a_data_rd <= a_mem[a_addr_rd];
      if (c_rd_en) c_data_rd <= c_mem[c_addr_rd];
      if (d_rd_en) d_data_rd <= d_mem[d_addr_rd];
   end

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int          obs_cyc_q[$];
   int          rd_log_q[$];
   int          done_n, done_cyc, first_rd_cyc, overlap_n;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Monitor on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (a_wr_en) begin obs_q.push_back({8'(a_addr_wr), a_data_wr}); obs_cyc_q.push_back(cyc); end
      if (c_wr_en) begin obs_q.push_back({8'(c_addr_wr), c_data_wr}); obs_cyc_q.push_back(cyc); end
      if (d_wr_en) begin obs_q.push_back({8'(d_addr_wr), d_data_wr}); obs_cyc_q.push_back(cyc); end
      if ((a_rd_en && a_wr_en) || (c_rd_en && c_wr_en) || (d_rd_en && d_wr_en)) overlap_n++;
      if (a_done || c_done || d_done) begin done_n++; done_cyc = cyc; end
      if ((a_rd_en || c_rd_en || d_rd_en) && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (c_rd_en) rd_log_q.push_back(int'(c_addr_rd));
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
      rd_log_q.delete();
      done_n       = 0;
      first_rd_cyc = -1;
      overlap_n    = 0;
   endtask

   task automatic start_frame(input int which, input logic [7:0] rb, input logic [5:0] wb,
                              input logic md, output int start_cyc);
      step();
      case (which)
         0: begin a_rbase = 5'(rb); a_wbase = 3'(wb); a_mode = md; a_start = 1'b1; end
         1: begin c_rbase = rb;     c_wbase = wb;     c_mode = md; c_start = 1'b1; end
         default: begin d_rbase = 3'(rb); d_wbase = 3'(wb); d_mode = md; d_start = 1'b1; end
      endcase
      start_cyc = cyc;
      step();
      a_start = 1'b0;
      c_start = 1'b0;
      d_start = 1'b0;
   endtask

   // Returns in the cycle omodule_done_f is high (or when the budget expires)
   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_n == 0 && n < budget) begin
         step();
         n++;
      end
      check_eq({tag, "_done"}, done_n, 1);
   endtask

   task automatic check_sb(input string tag);
      check_eq({tag, "_nwr"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check_eq($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
   endtask

   task automatic push_box();
      for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), 24'h102030});
   endtask

   // ---------------- stimulus ----------------
   int st, t_idle, n_before;
   logic [23:0] dec_val [8];

   initial begin
      rst_n = 1'b0;
      a_start = 0; a_mode = 0; a_rbase = '0; a_wbase = '0;
      c_start = 0; c_mode = 0; c_rbase = '0; c_wbase = '0;
      d_start = 0; d_mode = 0; d_rbase = '0; d_wbase = '0;
      clear_sb();
      repeat (3) step();

      // Reset state
      check_eq("rst_a_ctl", {a_rd_en, a_wr_en, a_work, a_done}, 0);
      check_eq("rst_a_bus", {a_addr_rd, a_addr_wr, a_data_wr}, 0);
      check_eq("rst_c_all", {c_rd_en, c_wr_en, c_work, c_done, c_addr_rd, c_addr_wr, c_data_wr}, 0);
      check_eq("rst_d_all", {d_rd_en, d_wr_en, d_work, d_done, d_addr_rd, d_addr_wr, d_data_wr}, 0);
      rst_n = 1'b1;
      repeat (2) step();
      check_eq("idle_work", a_work, 0);

      // Box average: uniform frame
      for (int i = 0; i < 32; i++) a_mem[i] = 24'h102030;
      clear_sb();
      push_box();
      start_frame(0, 8'd0, 6'd0, 1'b0, st);
      wait_done("box", 200);
      check_sb("box");
      check_eq("box_first_rd", first_rd_cyc, st + 1);
      check_eq("box_done_lat", done_cyc - first_rd_cyc, 48);
      check_eq("box_overlap", overlap_n, 0);

      // Start pulsed mid-frame is ignored; exactly one frame
      clear_sb();
      push_box();
      start_frame(0, 8'd0, 6'd0, 1'b0, st);
      repeat (10) step();
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      wait_done("mid", 200);
      repeat (60) step();
      check_sb("mid");
      check_eq("mid_done_once", done_n, 1);
      check_eq("mid_idle", a_work, 0);

      // Start held only across the DONE cycle is ignored
      clear_sb();
      push_box();
      start_frame(0, 8'd0, 6'd0, 1'b0, st);
      wait_done("dign", 200);
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      repeat (4) step();
      check_eq("dign_work", a_work, 0);
      check_eq("dign_rd", a_rd_en, 0);

      // Back-to-back: start in the first IDLE cycle is accepted
      clear_sb();
      push_box();
      start_frame(0, 8'd0, 6'd0, 1'b0, st);
      wait_done("b2b_a", 200);
      check_sb("b2b_a");
      clear_sb();
      push_box();
      a_start = 1'b1;
      step();
      t_idle = cyc;
      step();
      a_start = 1'b0;
      check_eq("b2b_rd_en", a_rd_en, 1);
      check_eq("b2b_first_rd", first_rd_cyc, t_idle + 1);
      wait_done("b2b_b", 200);
      check_sb("b2b_b");

      // Rounding: ch0 sum 5, ch1 sum 7, ch2 four 0xFF in block 0
      for (int i = 0; i < 32; i++) a_mem[i] = 24'h0;
      a_mem[0] = 24'hFF0101;
      a_mem[1] = 24'hFF0201;
      a_mem[8] = 24'hFF0201;
      a_mem[9] = 24'hFF0202;
      clear_sb();
      exp_q.push_back({8'd0, ROUND ? 24'hFF0201 : 24'hFF0101});
      for (int i = 1; i < 8; i++) exp_q.push_back({8'(i), 24'h0});
      start_frame(0, 8'd0, 6'd0, 1'b0, st);
      wait_done("rnd", 200);
      check_sb("rnd");

      // Decimate: pixel value = its address
      for (int i = 0; i < 32; i++) a_mem[i] = 24'(i);
      dec_val = '{24'd0, 24'd2, 24'd4, 24'd6, 24'd16, 24'd18, 24'd20, 24'd22};
      clear_sb();
      for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), dec_val[i]});
      start_frame(0, 8'd0, 6'd0, 1'b1, st);
      wait_done("dec", 100);
      check_sb("dec");
      check_eq("dec_first_wr", obs_cyc_q.size() > 0 ? obs_cyc_q[0] - first_rd_cyc : -1, 2);
      for (int i = 0; i + 1 < obs_cyc_q.size(); i++)
         check_eq($sformatf("dec_gap%0d", i), obs_cyc_q[i+1] - obs_cyc_q[i], 3);
      check_eq("dec_done_lat", done_cyc - first_rd_cyc, 24);

      // Reset mid-frame: outputs drop at once, no write, no done
      clear_sb();
      start_frame(0, 8'd0, 6'd0, 1'b0, st);
      repeat (10) step();
      check_eq("rmid_busy", a_work, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rmid_outs", {a_rd_en, a_wr_en, a_work, a_done, a_addr_rd, a_addr_wr, a_data_wr}, 0);
      n_before = obs_q.size();
      repeat (5) step();
      check_eq("rmid_nowr", obs_q.size(), n_before);
      check_eq("rmid_nodone", done_n, 0);
      rst_n = 1'b1;
      step();

      // Restart after reset: full decimate frame
      clear_sb();
      for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), dec_val[i]});
      start_frame(0, 8'd0, 6'd0, 1'b1, st);
      wait_done("rst_dec", 100);
      check_sb("rst_dec");

      // Base offsets and wrap on the 16x16 instance
      for (int i = 0; i < 256; i++) c_mem[i] = 24'(i);
      clear_sb();
      start_frame(1, 8'd100, 6'd5, 1'b0, st);
      wait_done("base", 1000);
      check_eq("base_nwr", obs_q.size(), 64);
      check_eq("base_nrd", rd_log_q.size(), 256);
      if (rd_log_q.size() >= 5) begin
         check_eq("base_rd0", rd_log_q[0], 100);
         check_eq("base_rd1", rd_log_q[1], 101);
         check_eq("base_rd2", rd_log_q[2], 116);
         check_eq("base_rd3", rd_log_q[3], 117);
         check_eq("base_rd4", rd_log_q[4], 102);
      end
      if (obs_q.size() == 64) begin
         check_eq("base_wr0", obs_q[0], {8'd5, ROUND ? 24'd109 : 24'd108});
         check_eq("base_wr63", obs_q[63], {8'd4, ROUND ? 24'd91 : 24'd90});
      end
      check_eq("base_done_lat", done_cyc - first_rd_cyc, 64 * 6);

      // pSCALE=1 copy of a ramp
      for (int i = 0; i < 8; i++) d_mem[i] = 24'h0A0B0C + 24'(i) * 24'h111111;
      clear_sb();
      for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), 24'h0A0B0C + 24'(i) * 24'h111111});
      start_frame(2, 8'd0, 6'd0, 1'b0, st);
      wait_done("copy", 100);
      check_sb("copy");
      check_eq("copy_done_lat", done_cyc - first_rd_cyc, 24);
      check_eq("copy_overlap", overlap_n, 0);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/im_downscale.md
# im_downscale

Parametrised frame downscaler: reads a stored image from frame memory, reduces it by an integer power-of-two factor per axis, and writes the result to a second memory region. Each output pixel is either the per-channel mean of its pSCALE×pSCALE input block (average mode) or the block's top-left pixel (decimate mode). It sits between the camera frame buffer and the preview/HDMI path. A control FSM starts it and observes its busy and done flags.

## Interface
- pIN_IM_WIDTH, 640, input width in pixels; must be a multiple of pSCALE
- pIN_IM_HEIGHT, 480, input height in pixels; must be a multiple of pSCALE
- pSCALE, 4, reduction factor per axis; power of two, 1..16
- pCHANNELS, 3, channels packed per pixel word
- pCH_W, 8, bits per channel; pixel word width = pCHANNELS*pCH_W (channel 0 in LSBs)
- Derived: OUT_W = pIN_IM_WIDTH/pSCALE, OUT_H = pIN_IM_HEIGHT/pSCALE, IN_AW = $clog2(pIN_IM_WIDTH*pIN_IM_HEIGHT), OUT_AW = $clog2(OUT_W*OUT_H), LS = $clog2(pSCALE)

Ports:
- iclk  in  1  clock. One clock; reset is asynchronous and active-low.
- irst_n  in  1  asynchronous active-low reset
- idata_rd  in  pCHANNELS*pCH_W  read data, valid exactly 1 cycle after omem_rd_en
- oaddr_rd  out  IN_AW  read address
- omem_rd_en  out  1  read strobe
- odata_wr  out  pCHANNELS*pCH_W  write data
- oaddr_wr  out  OUT_AW  write address
- omem_wr_en  out  1  write strobe, one cycle per output pixel
- irbase  in  IN_AW  input frame base address, sampled at start
- iwbase  in  OUT_AW  output frame base address, sampled at start
- imode  in  1  0 = average, 1 = decimate; sampled at start
- istart_work  in  1  start pulse
- omodule_work_f  out  1  high while a frame is in progress
- omodule_done_f  out  1  one-cycle pulse after the last write

## Operation
- States: IDLE, READ, LAST, WRITE, DONE.
- IDLE: on istart_work=1, latch irbase, iwbase and imode. Clear the counters ox, oy, kx, ky. Go to READ. istart_work is ignored in every other state.
- READ: assert omem_rd_en. oaddr_rd = rbase + (oy*pSCALE+ky)*pIN_IM_WIDTH + ox*pSCALE + kx.
  - Counter order: kx is innermost, then ky.
  - Average mode issues pSCALE² reads. Decimate mode issues one read (kx=ky=0).
  - After the final read, go to LAST.
- Accumulation: each cycle after a read, add every channel of idata_rd into its accumulator. Accumulators are pCH_W+2*LS bits wide and are cleared when the first sample of a block is loaded. LAST performs the final accumulate.
- WRITE: assert omem_wr_en. oaddr_wr = wbase + oy*OUT_W + ox.
  - Average mode: each channel = accumulator >> (2*LS), see Configuration.
  - Decimate mode: odata_wr = the sample as read.
  - Then advance ox; wrap to 0 at OUT_W and increment oy.
  - If the pixel written was (OUT_W-1, OUT_H-1), go to DONE; otherwise go to READ.
- DONE: pulse omodule_done_f for one cycle, then go to IDLE.
- omodule_work_f = 1 in READ, LAST and WRITE.
- Address arithmetic uses incremental row/column pointers. There are no runtime multipliers; only constant multiplies by powers of two and pIN_IM_WIDTH are allowed.
- Address sums wrap modulo 2^IN_AW and 2^OUT_AW. There is no bounds check on the base addresses.
- pSCALE=1: both modes copy the frame unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, accumulators and counters 0.
- Start: istart_work seen in cycle t gives the first omem_rd_en in cycle t+1.
- Per output pixel: average mode takes pSCALE²+2 cycles (reads, LAST, WRITE); decimate mode takes 3 cycles.
- Frame latency, average mode: OUT_W*OUT_H*(pSCALE²+2) cycles from the first read to the last write. omodule_done_f follows 1 cycle after the last write.
- omem_rd_en and omem_wr_en are never high in the same cycle.
- Back-to-back frames: istart_work asserted during DONE is ignored. istart_work in the first IDLE cycle is accepted.
- Reset mid-frame: state goes to IDLE immediately and all outputs go to 0. No partial write and no done pulse are produced.

## Configuration
- IM_DOWNSCALE_ROUND_EN defined: average mode rounds to nearest by adding 2^(2*LS-1) to the accumulator before the shift. The add is skipped when pSCALE=1. The result is saturated to 2^pCH_W-1.
- IM_DOWNSCALE_ROUND_EN undefined: plain truncating shift. Decimate mode is unaffected either way.

## Test plan
- Box average: 8×4 frame, pSCALE=2, pCHANNELS=3, pCH_W=8, all pixels 0x10_20_30 → 8 writes of 0x102030 at iwbase..iwbase+7. omodule_done_f occurs 48 cycles after the first read.
- Rounding: one 2×2 block with channel-0 values 1,1,1,2 (sum 5).
  - Truncating build writes 1.
  - Rounding build writes 1 (5+2=7, >>2).
  - With values 1,2,2,2 (sum 7): truncating writes 1, rounding writes 2.
  - With four 0xFF values under rounding: result is 0xFF, no overflow.
- Decimate: 8×4, pSCALE=2, pixel value = its input address → writes 0,2,4,6,16,18,20,22. Each output takes 3 cycles.
- Base offsets: irbase=100, iwbase=5 → first oaddr_rd=100, first oaddr_wr=5. Row step is 100+pIN_IM_WIDTH at ky=1.
- Control: istart_work pulsed mid-frame is ignored, and the frame completes exactly once. Asserting irst_n=0 mid-frame drops all outputs to 0 asynchronously. A restart after reset produces a full, correct frame.
- pSCALE=1 copy: a 4×2 ramp is written out identically, with 3 cycles per pixel.
